// File: rtl/im_loader_pkg.sv
// im_loader_pkg: shared IM geometry and loader state encodings
package im_loader_pkg;
  localparam int ARCH_WIDTH = 32;
  localparam int IM_WIDTH = 32;
  localparam int IM_DEPTH = 10;
  localparam int IM_SIZE = 2 ** IM_DEPTH;
  localparam logic [ARCH_WIDTH-1:0] IM_BASE_ADDR = '0;
  typedef enum logic [2:0] {
    LD_IDLE, LD_HDR0, LD_HDR1, LD_DATA, LD_CHK, LD_DONE, LD_ERR
  } ld_state_e;
endpackage

// File: rtl/im_word_packer.sv
// im_word_packer: gathers 4 bytes MSB-first into a PPC-ordered word and pulses word_valid
module im_word_packer
  import im_loader_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                byte_valid,
  input  logic [7:0]          byte_data,
  output logic [0:IM_WIDTH-1] wdata,
  output logic                word_valid
);
  logic [1:0]          r_idx;
  logic [0:IM_WIDTH-1] r_wdata;
  logic                r_valid;
  assign wdata = r_wdata;
  assign word_valid = r_valid;
  // drop each byte into its lane; pulse once the 4th lane is filled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= 2'd0;
      r_wdata <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= byte_valid && (r_idx == 2'd3);
      if (clr) r_idx <= 2'd0;
      else if (byte_valid) begin
        r_wdata[8*r_idx +: 8] <= byte_data;
        r_idx <= r_idx + 2'd1;
      end
    end
  end
endmodule

// File: rtl/im_loader.sv
// im_loader: byte-stream to IM write port boot loader; IM_LOADER_CHKSUM_EN adds a trailing XOR check byte
module im_loader
  import im_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  we,
  output logic [ARCH_WIDTH-1:0] waddr,
  output logic [0:IM_WIDTH-1]   wdata,
  output logic                  busy,
  output logic                  hold_cpu,
  output logic                  done,
  output logic                  err
);
  ld_state_e             r_state;
  logic [7:0]            r_cnt_hi;
  logic [17:0]           r_rem;
  logic [ARCH_WIDTH-1:0] r_waddr;
  logic                  r_done, r_err;
  logic                  w_acc, w_data_acc, w_start, w_chk_ok;
  logic [15:0]           w_n;
`ifdef IM_LOADER_CHKSUM_EN
  localparam ld_state_e L_END = LD_CHK;
  localparam bit L_CHK = 1'b1;
  logic [7:0] r_xor;
  assign w_chk_ok = (in_data == r_xor);
  // running XOR of payload bytes, restarted with each load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_xor <= 8'd0;
    else if (w_start) r_xor <= 8'd0;
    else if (w_data_acc) r_xor <= r_xor ^ in_data;
  end
`else
  localparam ld_state_e L_END = LD_DONE;
  localparam bit L_CHK = 1'b0;
  assign w_chk_ok = 1'b1;
`endif
  assign in_ready = (r_state == LD_HDR0) || (r_state == LD_HDR1) || (r_state == LD_DATA) || (r_state == LD_CHK);
  assign busy = in_ready;
  assign hold_cpu = busy;
  assign done = r_done;
  assign err = r_err;
  assign waddr = r_waddr;
  assign w_acc = in_valid && in_ready;
  assign w_data_acc = w_acc && (r_state == LD_DATA);
  assign w_start = start && ((r_state == LD_IDLE) || (r_state == LD_DONE) || (r_state == LD_ERR));
  assign w_n = {r_cnt_hi, in_data};
  im_word_packer u_packer (
    .clk(clk), .rst_n(rst_n), .clr(w_start), .byte_valid(w_data_acc),
    .byte_data(in_data), .wdata(wdata), .word_valid(we)
  );
  // frame sequencing: header, payload countdown, optional check byte, sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LD_IDLE;
      r_cnt_hi <= 8'd0;
      r_rem <= 18'd0;
      r_done <= 1'b0;
      r_err <= 1'b0;
    end else if (w_start) begin
      r_state <= LD_HDR0;
      r_done <= 1'b0;
      r_err <= 1'b0;
    end else if (w_acc) begin
      case (r_state)
        LD_HDR0: begin
          r_cnt_hi <= in_data;
          r_state <= LD_HDR1;
        end
        LD_HDR1: begin
          r_rem <= {w_n, 2'b00};
          if (w_n > 16'(IM_SIZE)) begin
            r_state <= LD_ERR;
            r_err <= 1'b1;
          end else if (w_n == 16'd0) begin
            r_state <= L_END;
            r_done <= ~L_CHK;
          end else r_state <= LD_DATA;
        end
        LD_DATA: begin
          r_rem <= r_rem - 18'd1;
          if (r_rem == 18'd1) begin
            r_state <= L_END;
            r_done <= ~L_CHK;
          end
        end
        LD_CHK: begin
          r_state <= w_chk_ok ? LD_DONE : LD_ERR;
          r_done <= w_chk_ok;
          r_err <= ~w_chk_ok;
        end
        default: ;
      endcase
    end
  end
  // word address: rebased on start, stepped after every write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_waddr <= '0;
    else if (w_start) r_waddr <= IM_BASE_ADDR;
    else if (we) r_waddr <= r_waddr + 32'd4;
  end
endmodule
